// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- 32-bit integer ALU for the RISC-V execute stage.
//
// Computes add/sub, shifts, bitwise logic, signed/unsigned compares and the
// low word of a 32x32 multiply in one combinational pass. Result and flags
// are captured in output registers, giving a fixed one-cycle latency with a
// new operation accepted every cycle.
//
// Ports
//   clk      in   1   clock, rising-edge active
//   rst      in   1   synchronous reset, active-high (clears all outputs)
//   A        in  32   operand A (rs1)
//   B        in  32   operand B (rs2 or immediate)
//   ALUop    in   4   operation select
//   ALUout   out 32   registered result
//   ZeroFlag out  1   registered: ALUout == 0
//   BLT      out  1   registered: A < B, compare ops only
//   BGT      out  1   registered: A > B, compare ops only
// -----------------------------------------------------------------------------
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALUop,
    output logic [31:0] ALUout,
    output logic        ZeroFlag,
    output logic        BLT,
    output logic        BGT
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_SRA  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_CMPS = 4'b1000;
    localparam logic [3:0] OP_CMPU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    logic [31:0] result_s;
    logic        lt_s;
    logic        gt_s;
    logic        zero_s;
    logic [4:0]  shamt_s;
    logic [31:0] diff_s;
    logic [63:0] product_s;

    // Shared operand preprocessing: only the low five bits of B shift.
    always_comb begin
        shamt_s   = B[4:0];
        diff_s    = A - B;
        product_s = {32'd0, A} * {32'd0, B};
    end

    // Operation decode: result and compare flags for the current inputs.
    always_comb begin
        result_s = 32'd0;
        lt_s     = 1'b0;
        gt_s     = 1'b0;
        case (ALUop)
            OP_ADD:  result_s = A + B;
            OP_SUB:  result_s = diff_s;
            OP_SLL:  result_s = A << shamt_s;
            OP_SRL:  result_s = A >> shamt_s;
            OP_SRA:  result_s = $unsigned($signed(A) >>> shamt_s);
            OP_AND:  result_s = A & B;
            OP_OR:   result_s = A | B;
            OP_XOR:  result_s = A ^ B;
            OP_CMPS: begin
                result_s = diff_s;
                lt_s     = ($signed(A) < $signed(B));
                gt_s     = ($signed(A) > $signed(B));
            end
            OP_CMPU: begin
                result_s = diff_s;
                lt_s     = (A < B);
                gt_s     = (A > B);
            end
            // Low word is identical for signed and unsigned operands.
            OP_MUL:  result_s = product_s[31:0];
            default: result_s = 32'd0;
        endcase
    end

    // Zero detect on the value that will be registered into ALUout.
    always_comb begin
        if (result_s == 32'd0) begin
            zero_s = 1'b1;
        end else begin
            zero_s = 1'b0;
        end
    end

    // Output registers with synchronous reset taking priority over any op.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUout   <= 32'd0;
            ZeroFlag <= 1'b0;
            BLT      <= 1'b0;
            BGT      <= 1'b0;
        end else begin
            ALUout   <= result_s;
            ZeroFlag <= zero_s;
            BLT      <= lt_s;
            BGT      <= gt_s;
        end
    end

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
// Directed steps with hand-derived expectations, then randomized vectors
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic [31:0] ALUout;
    logic        ZeroFlag;
    logic        BLT;
    logic        BGT;

    int vectors;
    int miscompares;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .ALUop    (ALUop),
        .ALUout   (ALUout),
        .ZeroFlag (ZeroFlag),
        .BLT      (BLT),
        .BGT      (BGT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: results derived from integer arithmetic on wide values.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         output logic [31:0] r, output logic z, output logic lt, output logic gt);
        longint sa, sb, ua, ub, pw, q;
        logic [63:0] prod;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(b % 32'd32);
        pw = longint'(1) << sh;
        lt = 1'b0;
        gt = 1'b0;
        r  = 32'd0;
        case (op)
            4'd0:  r = 32'(ua + ub);
            4'd1:  r = 32'(ua - ub);
            4'd2:  r = 32'(ua * pw);
            4'd3:  r = 32'(ua / pw);
            4'd4: begin
                // floor division of the signed value by 2^sh
                if (sa >= 0) q = sa / pw;
                else         q = -((-sa + pw - 1) / pw);
                r = 32'(q);
            end
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8: begin
                r  = 32'(ua - ub);
                lt = (sa < sb);
                gt = (sa > sb);
            end
            4'd9: begin
                r  = 32'(ua - ub);
                lt = (ua < ub);
                gt = (ua > ub);
            end
            4'd12: begin
                prod = {32'd0, a} * {32'd0, b};
                r = prod[31:0];
            end
            default: r = 32'd0;
        endcase
        z = (r == 32'd0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one op for one edge, then compare all outputs with given values.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] er, input logic ez,
                        input logic elt, input logic egt);
        A = a; B = b; ALUop = op;
        @(posedge clk);
        #1;
        check({tag, ".out"}, ALUout, er);
        check({tag, ".z"},   {31'd0, ZeroFlag}, {31'd0, ez});
        check({tag, ".blt"}, {31'd0, BLT}, {31'd0, elt});
        check({tag, ".bgt"}, {31'd0, BGT}, {31'd0, egt});
    endtask

    // Apply one op and compare against the reference model.
    task automatic step_model(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op);
        logic [31:0] er;
        logic ez, elt, egt;
        model(a, b, op, er, ez, elt, egt);
        step(tag, a, b, op, er, ez, elt, egt);
        check({tag, ".excl"}, {31'd0, BLT & BGT}, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            4:       v = 32'($urandom_range(0, 40));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; A = 32'd3; B = 32'd12; ALUop = 4'b0000;

        // Reset overrides an ADD in the same cycle.
        step("reset", 32'd3, 32'd12, 4'b0000, 32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("add", 32'd3, 32'd12, 4'b0000, 32'd15, 1'b0, 1'b0, 1'b0);

        step("sub", 32'd3, 32'd12, 4'b0001, 32'hFFFF_FFF7, 1'b0, 1'b0, 1'b0);
        step("sll", 32'd3, 32'd12, 4'b0010, 32'h0000_3000, 1'b0, 1'b0, 1'b0);
        step("srl", 32'd3, 32'd12, 4'b0011, 32'd0, 1'b1, 1'b0, 1'b0);
        step("sra", 32'd3, 32'd12, 4'b0100, 32'd0, 1'b1, 1'b0, 1'b0);
        step("and", 32'd3, 32'd12, 4'b0101, 32'd0, 1'b1, 1'b0, 1'b0);
        step("or",  32'd3, 32'd12, 4'b0110, 32'd15, 1'b0, 1'b0, 1'b0);
        step("xor", 32'd3, 32'd12, 4'b0111, 32'd15, 1'b0, 1'b0, 1'b0);
        step("mul", 32'd3, 32'd12, 4'b1100, 32'd36, 1'b0, 1'b0, 1'b0);

        step("cmps_3_12", 32'd3, 32'd12, 4'b1000, 32'hFFFF_FFF7, 1'b0, 1'b1, 1'b0);
        step("cmpu_3_12", 32'd3, 32'd12, 4'b1001, 32'hFFFF_FFF7, 1'b0, 1'b1, 1'b0);

        step("cmps_min", 32'h8000_0000, 32'd1, 4'b1000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        step("cmpu_min", 32'h8000_0000, 32'd1, 4'b1001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        step("sra_neg",  32'h8000_0000, 32'd4, 4'b0100, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        step("srl_neg",  32'h8000_0000, 32'd4, 4'b0011, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        // Upper bits of B are ignored and a shift of 0 passes A through.
        step("sll_big",  32'h0000_0001, 32'hFFFF_FFE4, 4'b0010, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        step("sra_zero", 32'h8765_4321, 32'h0000_0020, 4'b0100, 32'h8765_4321, 1'b0, 1'b0, 1'b0);

        step("cmps_eq", 32'd5, 32'd5, 4'b1000, 32'd0, 1'b1, 1'b0, 1'b0);
        step("cmpu_eq", 32'd5, 32'd5, 4'b1001, 32'd0, 1'b1, 1'b0, 1'b0);
        step("mul_neg", 32'hFFFF_FFFF, 32'd2, 4'b1100, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        step("rsvd_d",  32'd7, 32'd9, 4'b1101, 32'd0, 1'b1, 1'b0, 1'b0);
        step("rsvd_a",  32'd7, 32'd9, 4'b1010, 32'd0, 1'b1, 1'b0, 1'b0);

        // Mid-stream reset while a compare that would set BLT is applied.
        step("pre_rst", 32'd1, 32'd2, 4'b1001, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step("mid_rst", 32'd1, 32'd2, 4'b1001, 32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("resume",  32'd20, 32'd22, 4'b0000, 32'd42, 1'b0, 1'b0, 1'b0);

        // Randomized back-to-back ops against the reference model.
        for (int i = 0; i < 400; i++) begin
            ra  = pick_operand();
            rb  = ($urandom_range(0, 7) == 0) ? ra : pick_operand();
            rop = 4'($urandom_range(0, 15));
            step_model($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
